// File: rtl/find_max_pipe.sv
// find_max_pipe: pipelined binary-tree maximum search over a packed vector.
// Define FIND_MAX_INDEX_EN to carry per-stage index registers and drive index_out.
module find_max_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 32,
    parameter int SIGNED     = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic [$clog2(NUM_INPUTS)-1:0]    index_out
);

    localparam int LOG2N = $clog2(NUM_INPUTS);
    localparam int NODES = NUM_INPUTS - 1;

    logic                  en;
    logic [LOG2N-1:0]      vld_q;
    logic [DATA_WIDTH-1:0] in_val [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] val_d  [NODES];
    logic [DATA_WIDTH-1:0] val_q  [NODES];
`ifdef FIND_MAX_INDEX_EN
    logic [LOG2N-1:0]      idx_d  [NODES];
    logic [LOG2N-1:0]      idx_q  [NODES];
`endif

    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++)
            in_val[i] = data_in[(NUM_INPUTS-i)*DATA_WIDTH-1 -: DATA_WIDTH];
    end

    // Tree nodes are packed stage by stage into one flat array: stage k starts
    // at NUM_INPUTS - (NUM_INPUTS >> k) and holds NUM_INPUTS >> (k+1) entries.
    for (genvar k = 0; k < LOG2N; k++) begin : g_stage
        localparam int M    = NUM_INPUTS >> (k + 1);
        localparam int BASE = NUM_INPUTS - (NUM_INPUTS >> k);
        for (genvar j = 0; j < M; j++) begin : g_node
            logic [DATA_WIDTH-1:0] a_val;
            logic [DATA_WIDTH-1:0] b_val;
            logic                  take_b;
`ifdef FIND_MAX_INDEX_EN
            logic [LOG2N-1:0]      a_idx;
            logic [LOG2N-1:0]      b_idx;
`endif
            if (k == 0) begin : g_leaf
                assign a_val = in_val[j];
                assign b_val = in_val[j + M];
`ifdef FIND_MAX_INDEX_EN
                assign a_idx = LOG2N'(j);
                assign b_idx = LOG2N'(j + M);
`endif
            end else begin : g_inner
                localparam int PREV = NUM_INPUTS - (NUM_INPUTS >> (k - 1));
                assign a_val = val_q[PREV + j];
                assign b_val = val_q[PREV + j + M];
`ifdef FIND_MAX_INDEX_EN
                assign a_idx = idx_q[PREV + j];
                assign b_idx = idx_q[PREV + j + M];
`endif
            end
`ifdef FIND_MAX_INDEX_EN
            // Upper-half entry may already hold a lower index, so ties compare indices.
            assign take_b = greater(b_val, a_val) || ((b_val == a_val) && (b_idx < a_idx));
            assign idx_d[BASE + j] = take_b ? b_idx : a_idx;
`else
            assign take_b = greater(b_val, a_val);
`endif
            assign val_d[BASE + j] = take_b ? b_val : a_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < NODES; i++) begin
                val_q[i] <= '0;
`ifdef FIND_MAX_INDEX_EN
                idx_q[i] <= '0;
`endif
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            for (int unsigned k = 1; k < LOG2N; k++)
                vld_q[k] <= vld_q[k-1];
            val_q <= val_d;
`ifdef FIND_MAX_INDEX_EN
            idx_q <= idx_d;
`endif
        end
    end

    assign out_valid = vld_q[LOG2N-1];
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en;
    assign data_out  = val_q[NODES-1];
`ifdef FIND_MAX_INDEX_EN
    assign index_out = idx_q[NODES-1];
`else
    assign index_out = '0;
`endif

endmodule

// File: tb/tb_find_max_pipe.sv
// tb_find_max_pipe: directed checks of find_max_pipe (unsigned, signed and 2-input builds).
module tb_find_max_pipe;

    localparam int DW = 32;
    localparam int N  = 32;
    localparam int LG = 5;
`ifdef FIND_MAX_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [N*DW-1:0] data_in = '0;
    logic [N*DW-1:0] vec = '0;

    logic          in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [DW-1:0] data_out_u, data_out_s;
    logic [LG-1:0] index_out_u, index_out_s;

    logic          in_valid2 = 1'b0;
    logic [15:0]   data_in2 = '0;
    logic          in_ready2, out_valid2;
    logic [7:0]    data_out2;
    logic [0:0]    index_out2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    find_max_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .data_in(data_in), .out_valid(out_valid_u), .out_ready(out_ready),
        .data_out(data_out_u), .index_out(index_out_u));

    find_max_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .data_in(data_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .data_out(data_out_s), .index_out(index_out_s));

    find_max_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(2), .SIGNED(1)) u_dut_2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .data_in(data_in2), .out_valid(out_valid2), .out_ready(1'b1),
        .data_out(data_out2), .index_out(index_out2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LG-1:0] ei(input int i);
        if (IDX_EN) return LG'(i);
        return '0;
    endfunction

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) vec[(N-i)*DW-1 -: DW] = v;
    endtask

    task automatic put(input int i, input logic [DW-1:0] v);
        vec[(N-i)*DW-1 -: DW] = v;
    endtask

    // One vector through both 32-input instances; result must appear LG cycles after acceptance.
    task automatic run_single(input string tag, input logic [DW-1:0] exp_u, input int idx_u,
                              input logic [DW-1:0] exp_s, input int idx_s);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        data_in  = vec;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready_u, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid_u) break;
        end
        check({tag, "_lat"}, lat, LG);
        check({tag, "_du"}, data_out_u, exp_u);
        check({tag, "_iu"}, index_out_u, ei(idx_u));
        check({tag, "_vs"}, out_valid_s, 1);
        check({tag, "_ds"}, data_out_s, exp_s);
        check({tag, "_is"}, index_out_s, ei(idx_s));
        @(negedge clk);
        check({tag, "_fall"}, out_valid_u, 0);
    endtask

    task automatic run_small(input string tag, input logic [15:0] v,
                             input logic [7:0] exp_d, input int exp_i);
        @(posedge clk); #1;
        in_valid2 = 1'b1;
        data_in2  = v;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check({tag, "_v"}, out_valid2, 1);
        check({tag, "_d"}, data_out2, exp_d);
        check({tag, "_i"}, index_out2, IDX_EN ? exp_i : 0);
        @(negedge clk);
        check({tag, "_fall"}, out_valid2, 0);
    endtask

    // Eight back-to-back vectors; out_ready low during cycles 6..8.
    task automatic run_stream();
        int sent, rcv, cyc;
        sent = 0; rcv = 0; cyc = 0;
        @(posedge clk); #1;
        while (rcv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                fill(DW'(sent));
                put((sent * 5 + 2) % N, 32'h100 + sent);
                in_valid = 1'b1;
                data_in  = vec;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 6 && cyc <= 8) begin
                check("stall_rdy", in_ready_u, 0);
                check("stall_vld", out_valid_u, 1);
                check("hold_data", data_out_u, 32'h100 + rcv);
                check("hold_idx", index_out_u, ei((rcv * 5 + 2) % N));
            end
            if (out_valid_u && out_ready) begin
                check("strm_data", data_out_u, 32'h100 + rcv);
                check("strm_idx", index_out_u, ei((rcv * 5 + 2) % N));
                rcv++;
            end
            if (in_valid && in_ready_u) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("strm_cnt", rcv, 8);
        check("strm_sent", sent, 8);
        @(negedge clk);
        check("strm_nodup", out_valid_u, 0);
    endtask

    task automatic run_reset_flush();
        int seen;
        for (int a = 0; a < 3; a++) begin
            @(posedge clk); #1;
            fill('0);
            put(a + 4, 32'h200 + a);
            in_valid = 1'b1;
            data_in  = vec;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_vld", out_valid_u, 1);
        check("pre_rst_data", data_out_u, 32'h200);
        rst_n = 1'b0;
        #1;
        check("rst_vld", out_valid_u, 0);
        check("rst_data", data_out_u, 0);
        check("rst_idx", index_out_u, 0);
        check("rst_rdy", in_ready_u, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid_u) seen++;
        end
        check("rst_flush", seen, 0);
        fill('0);
        put(11, 32'h0000_00AB);
        run_single("post_rst", 32'h0000_00AB, 11, 32'h0000_00AB, 11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_vld", out_valid_u, 0);
        check("reset_rdy", in_ready_u, 1);
        check("reset_data", data_out_u, 0);
        check("reset_idx", index_out_u, 0);
        check("reset_vld2", out_valid2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill('0);
        put(17, 32'hFFFF_FFFF);
        run_single("one_hot", 32'hFFFF_FFFF, 17, 32'h0, 0);

        fill(32'h5);
        run_single("all_eq", 32'h5, 0, 32'h5, 0);

        fill(32'h8000_0000);
        put(3, 32'hFFFF_FFFF);
        put(9, 32'h0000_0001);
        run_single("sign_mix", 32'hFFFF_FFFF, 3, 32'h1, 9);

        fill('0);
        put(1, 32'h9);
        put(16, 32'h9);
        run_single("tie_cross", 32'h9, 1, 32'h9, 1);

        fill('0);
        put(0, 32'h7FFF_FFFF);
        put(31, 32'hFFFF_FFFF);
        run_single("extremes", 32'hFFFF_FFFF, 31, 32'h7FFF_FFFF, 0);

        run_stream();
        run_reset_flush();

        run_small("n2_sgn", {8'h80, 8'h7F}, 8'h7F, 1);
        run_small("n2_tie", {8'h05, 8'h05}, 8'h05, 0);
        run_small("n2_max", {8'h7F, 8'h80}, 8'h7F, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
